// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches one instruction word as sequential bytes and strobes the MDR; FETCH_TIMEOUT_EN adds a REQ wait timeout
module fetch_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int TIMEOUT_CYC    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              mdr_re,
  output logic              mdr_shift,
  output logic              mdr_we,
  output logic              busy,
  output logic              done,
  output logic              fetch_err
);
  localparam int CW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_SHIFT, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [CW-1:0] r_cnt;
  logic w_timeout;
`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait;
  logic r_err;
  assign w_timeout = r_state == S_REQ && !mem_ack && r_wait == TW'(TIMEOUT_CYC - 1);
  assign fetch_err = r_err;
  // wait counter restarts on every REQ entry; error pulse follows the abandoning cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= (r_state == S_REQ && w_next == S_REQ) ? r_wait + TW'(1) : '0;
      r_err  <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
  assign pc_out    = r_pc;
  assign busy      = r_state != S_IDLE;
  assign mem_rd    = r_state == S_REQ;
  assign mem_addr  = mem_rd ? r_pc : '0;
  assign mdr_re    = r_state == S_LOAD;
  assign mdr_shift = r_state == S_SHIFT;
  assign mdr_we    = r_state == S_WRITE;
  assign done      = r_state == S_DONE;
  // next-state decode; start is only looked at in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_REQ : S_IDLE;
      S_REQ:   w_next = w_timeout ? S_IDLE : mem_ack ? S_LOAD : S_REQ;
      S_LOAD:  w_next = r_cnt < CW'(BYTES_PER_WORD - 1) ? S_SHIFT : S_WRITE;
      S_SHIFT: w_next = S_REQ;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // state, PC and byte count; a same-cycle pc_load and start fetches from pc_in
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && pc_load) r_pc <= pc_in;
      else if (r_state == S_LOAD) r_pc <= r_pc + ADDR_W'(1);
      if (r_state == S_IDLE && start) r_cnt <= '0;
      else if (r_state == S_SHIFT) r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule
